irq_ack_controller: RTL and testbench
=====================================

Name: irq_ack_controller

Overview:
- CPU-side responder for the interrupt priority encoder.
- Consumes the encoder's IRQ/vector pair, latches the winning vector, and presents it to the core as a held request.
- Runs the acknowledge/end-of-interrupt handshake and returns a one-cycle one-hot clear to the source line being serviced.
- Sits between the priority encoder and the core's trap/exception logic.

Parameters:
- N_IRQ, 4, number of interrupt source lines; must be a power of two.
- VEC_W, 2, vector width; equals log2(N_IRQ).
- ACK_TIMEOUT, 16, cycles allowed in REQ before abandoning the request; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- IRQ  in  1  encoder valid; at least one source is pending.
- y  in  VEC_W  encoder vector; 0 is highest priority.
- int_req  out  1  request to the core.
- int_vector  out  VEC_W  latched vector; stable while int_req or in_service is set.
- int_ack  in  1  core accepts the request (single-cycle pulse).
- eoi  in  1  core finished the handler (single-cycle pulse).
- irq_clear  out  N_IRQ  one-hot, one-cycle clear to the source latch.
- in_service  out  N_IRQ  one-hot mask of the vector being serviced.
- irq_done  out  1  one-cycle pulse on EOI completion.
- timeout_err  out  1  one-cycle pulse on ack timeout; tied 0 when the optional feature is off.

Behaviour:
- Reset: all outputs are 0, int_vector is 0, the state is IDLE and the counter is 0. Reset applies mid-handshake with no pulses issued.
- The design uses 4 states: IDLE, REQ, SERVICE, GUARD.
- IDLE: if IRQ=1, latch y into int_vector and go to REQ. int_req rises on the next cycle, so latency from IRQ to int_req is 1 cycle.
- REQ:
  - int_req=1 and int_vector is held.
  - Changes on IRQ or y are ignored; the request stays latched even if IRQ drops.
  - On int_ack=1, go to SERVICE. That edge drops int_req, sets in_service[int_vector], and pulses irq_clear[int_vector] for exactly 1 cycle.
- SERVICE:
  - in_service is held.
  - On eoi=1, clear in_service, pulse irq_done for 1 cycle, and go to GUARD.
  - int_ack in SERVICE is ignored.
- GUARD: lasts exactly 1 cycle, ignores IRQ (this absorbs the encoder's registered-output lag after the clear), then goes to IDLE.
- Ignored inputs and stray pulses:
  - int_ack in IDLE or GUARD is ignored.
  - eoi outside SERVICE is ignored.
  - int_ack and eoi asserted together in REQ: the ack is taken, the eoi is dropped.
- Back-to-back requests: with IRQ held high, the minimum interval from one EOI to the next int_req is 3 cycles (GUARD, IDLE latch, REQ).
- Only one interrupt is in service at a time; there is no nesting. A higher-priority arrival waits until GUARD completes.
- Width rule: irq_clear and in_service are decoded from int_vector as 1<<int_vector and are N_IRQ bits wide.

Optional Feature:
- Macro: IRQ_ACK_TIMEOUT_EN.
- Enabled:
  - A cycle counter of width clog2(ACK_TIMEOUT+1) runs in REQ and clears on REQ entry.
  - If ACK_TIMEOUT cycles elapse with no int_ack: int_req drops, timeout_err pulses for 1 cycle, no irq_clear is issued (the source stays pending), and the state goes to GUARD.
  - An int_ack arriving in the same cycle the count expires wins; no timeout is raised.
- Disabled: REQ waits indefinitely, there is no counter, and timeout_err is tied 0.

Decomposition:
- Shared package irq_pkg holds:
  - the N_IRQ and VEC_W defaults;
  - the state enum type irq_state_t (IDLE, REQ, SERVICE, GUARD);
  - the ACK_TIMEOUT default;
  - the helper function onehot_from_vec used by this block and the encoder bench.
- No sub-module. The timeout counter is small and stays inline, guarded by the macro.

Test Plan:
- Reset, then IRQ=1 with y=2'b10 -> int_req=1 with int_vector=2 one cycle later. Then int_ack -> next cycle int_req=0, irq_clear=4'b0100 for 1 cycle, in_service=4'b0100.
- In SERVICE, pulse eoi -> in_service=0, irq_done for 1 cycle, and IRQ is ignored for one GUARD cycle. With IRQ=1 and y=0 held, int_req returns 3 cycles after eoi with int_vector=0.
- In REQ with int_vector=3, change y to 0 and drop IRQ -> int_vector stays 3 and int_req stays 1 until int_ack.
- Stray int_ack in IDLE and stray eoi in REQ -> no state change and no pulses. int_ack and eoi together in REQ -> SERVICE entered and in_service remains set.
- Assert rst mid-SERVICE -> next cycle all outputs are 0 and the state is IDLE, with no irq_done.
- With IRQ_ACK_TIMEOUT_EN and ACK_TIMEOUT=16, no int_ack after a request -> the cycle after the 16th REQ cycle has int_req=0 and one timeout_err pulse, with irq_clear staying 0. With IRQ still 1, the request is reissued after GUARD.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt acknowledge path.
// Holds the default geometry (N_IRQ, VEC_W), the acknowledge timeout default,
// the controller state type and the vector-to-one-hot helper that is shared with
// the priority encoder bench.
package irq_pkg;

    localparam int unsigned N_IRQ_DEFAULT       = 4;
    localparam int unsigned VEC_W_DEFAULT       = 2;
    localparam int unsigned ACK_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2,
        StGuard   = 2'd3
    } irq_state_t;

    // Callers truncate the result to their own N_IRQ width.
    function automatic logic [31:0] onehot_from_vec(input logic [31:0] vec);
        return 32'd1 << vec;
    endfunction

endpackage

// File: rtl/irq_ack_controller_if.sv
// Handshake bundle between the priority encoder, the acknowledge controller and
// the core.
//   master : controller side (drives int_req, int_vector, irq_clear, in_service,
//            irq_done, timeout_err; samples IRQ, y, int_ack, eoi)
//   slave  : environment side (encoder plus core), the mirror image
interface irq_ack_controller_if
    import irq_pkg::*;
#(
    parameter int unsigned N_IRQ = N_IRQ_DEFAULT,
    parameter int unsigned VEC_W = VEC_W_DEFAULT
);

    logic             IRQ;
    logic [VEC_W-1:0] y;
    logic             int_req;
    logic [VEC_W-1:0] int_vector;
    logic             int_ack;
    logic             eoi;
    logic [N_IRQ-1:0] irq_clear;
    logic [N_IRQ-1:0] in_service;
    logic             irq_done;
    logic             timeout_err;

    modport master (
        input  IRQ,
        input  y,
        input  int_ack,
        input  eoi,
        output int_req,
        output int_vector,
        output irq_clear,
        output in_service,
        output irq_done,
        output timeout_err
    );

    modport slave (
        output IRQ,
        output y,
        output int_ack,
        output eoi,
        input  int_req,
        input  int_vector,
        input  irq_clear,
        input  in_service,
        input  irq_done,
        input  timeout_err
    );

endinterface

// File: rtl/irq_ack_controller.sv
// CPU-side responder for the interrupt priority encoder.
// Latches the winning vector, holds a request to the core, runs the
// acknowledge / end-of-interrupt handshake and returns a one-cycle one-hot clear
// to the serviced source line. One interrupt in service at a time, no nesting.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : irq_ack_controller_if.master
//          IRQ/y in from the encoder, int_ack/eoi in from the core,
//          int_req/int_vector/in_service/irq_done/timeout_err out to the core,
//          irq_clear out to the source latches.
//
// Optional feature: define IRQ_ACK_TIMEOUT_EN to abandon a request that is not
// acknowledged within ACK_TIMEOUT cycles (timeout_err pulse, no clear issued).
module irq_ack_controller
    import irq_pkg::*;
#(
    parameter int unsigned N_IRQ       = N_IRQ_DEFAULT,
    parameter int unsigned VEC_W       = VEC_W_DEFAULT,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_ack_controller_if.master bus
);

    // Elaboration-time sanity checks on the geometry.
    if (N_IRQ != (32'd1 << VEC_W)) begin : g_bad_geometry
        $error("irq_ack_controller: N_IRQ must equal 2**VEC_W");
    end
    if (ACK_TIMEOUT == 0) begin : g_bad_timeout
        $error("irq_ack_controller: ACK_TIMEOUT must be non-zero");
    end

    irq_state_t       state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             clear_q, clear_d;
    logic             done_q, done_d;
    logic             tmo_d;
    logic [N_IRQ-1:0] vec_onehot;

`ifdef IRQ_ACK_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tmo_q;
    logic            expired;

    // cnt_q counts completed REQ cycles; the last allowed one ends at ACK_TIMEOUT-1.
    assign expired = (cnt_q == CntW'(ACK_TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        clear_d = 1'b0;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
`ifdef IRQ_ACK_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.IRQ) begin
                    vec_d   = bus.y;
                    state_d = StReq;
`ifdef IRQ_ACK_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StReq: begin
                // An ack always wins, including over a simultaneous eoi or expiry.
                if (bus.int_ack) begin
                    state_d = StService;
                    clear_d = 1'b1;
                end
`ifdef IRQ_ACK_TIMEOUT_EN
                else if (expired) begin
                    state_d = StGuard;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StService: begin
                if (bus.eoi) begin
                    state_d = StGuard;
                    done_d  = 1'b1;
                end
            end
            // One dead cycle so the encoder's registered output catches up with the clear.
            StGuard: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            clear_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            clear_q <= clear_d;
            done_q  <= done_d;
        end
    end

`ifdef IRQ_ACK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign bus.timeout_err = tmo_q;
`else
    assign bus.timeout_err = tmo_d;
`endif

    assign vec_onehot     = N_IRQ'(onehot_from_vec(32'(vec_q)));
    assign bus.int_req    = (state_q == StReq);
    assign bus.int_vector = vec_q;
    assign bus.irq_clear  = clear_q ? vec_onehot : '0;
    assign bus.in_service = (state_q == StService) ? vec_onehot : '0;
    assign bus.irq_done   = done_q;

endmodule

// File: tb/tb_irq_ack_controller.sv
// Self-checking bench for irq_ack_controller: directed handshake scenarios
// followed by randomized traffic, all compared against a transaction-level model.
module tb_irq_ack_controller;

    localparam int unsigned N_IRQ       = 4;
    localparam int unsigned VEC_W       = 2;
    localparam int unsigned ACK_TIMEOUT = 16;

    logic clk;
    logic rst;

    irq_ack_controller_if #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) bus ();

    irq_ack_controller #(
        .N_IRQ      (N_IRQ),
        .VEC_W      (VEC_W),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    // Reference model: what the interrupt handshake is doing, not how.
    bit m_pending;    // request presented, awaiting ack
    bit m_serving;    // handler running, awaiting eoi
    bit m_guard;      // one-cycle hold-off after completion/abandon
    int m_vec;
    int m_wait;       // REQ cycles completed without ack
    bit e_clear, e_done, e_tmo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit irq, input int y, input bit ack,
                              input bit eoi);
        e_clear = 0;
        e_done  = 0;
        e_tmo   = 0;
        if (r) begin
            m_pending = 0; m_serving = 0; m_guard = 0; m_vec = 0; m_wait = 0;
        end else if (m_guard) begin
            m_guard = 0;
        end else if (m_serving) begin
            if (eoi) begin m_serving = 0; m_guard = 1; e_done = 1; end
        end else if (m_pending) begin
            if (ack) begin
                m_pending = 0; m_serving = 1; e_clear = 1;
            end else begin
                m_wait++;
`ifdef IRQ_ACK_TIMEOUT_EN
                if (m_wait == ACK_TIMEOUT) begin m_pending = 0; m_guard = 1; e_tmo = 1; end
`endif
            end
        end else if (irq) begin
            m_pending = 1; m_vec = y; m_wait = 0;
        end
    endtask

    task automatic step(input bit r, input bit irq, input int y, input bit ack, input bit eoi);
        logic [3:0] oh;
        rst         = r;
        bus.IRQ     = irq;
        bus.y       = 2'(y);
        bus.int_ack = ack;
        bus.eoi     = eoi;
        @(posedge clk);
        model_edge(r, irq, y, ack, eoi);
        #1;
        oh = 4'(1 << m_vec);
        check("int_req",     32'(bus.int_req),     32'(m_pending));
        check("int_vector",  32'(bus.int_vector),  32'(m_vec));
        check("irq_clear",   32'(bus.irq_clear),   e_clear ? 32'(oh) : 32'd0);
        check("in_service",  32'(bus.in_service),  m_serving ? 32'(oh) : 32'd0);
        check("irq_done",    32'(bus.irq_done),    32'(e_done));
        check("timeout_err", 32'(bus.timeout_err), 32'(e_tmo));
    endtask

    initial begin
        rst = 1'b1; bus.IRQ = 1'b0; bus.y = '0; bus.int_ack = 1'b0; bus.eoi = 1'b0;
        m_pending = 0; m_serving = 0; m_guard = 0; m_vec = 0; m_wait = 0;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 1, 3, 1, 1);
        check("rst_req", 32'(bus.int_req), 32'd0);
        check("rst_vec", 32'(bus.int_vector), 32'd0);
        check("rst_svc", 32'(bus.in_service), 32'd0);

        // Request vector 2, ack, clear, service, eoi, guard, back-to-back reissue
        step(0, 1, 2, 0, 0);
        check("req2_req", 32'(bus.int_req), 32'd1);
        check("req2_vec", 32'(bus.int_vector), 32'd2);
        step(0, 0, 0, 1, 0);
        check("ack2_clear", 32'(bus.irq_clear), 32'h4);
        check("ack2_svc", 32'(bus.in_service), 32'h4);
        check("ack2_req", 32'(bus.int_req), 32'd0);
        step(0, 1, 0, 0, 0);
        check("svc2_clear", 32'(bus.irq_clear), 32'd0);
        check("svc2_svc", 32'(bus.in_service), 32'h4);
        step(0, 1, 0, 0, 1);
        check("eoi2_svc", 32'(bus.in_service), 32'd0);
        check("eoi2_done", 32'(bus.irq_done), 32'd1);
        step(0, 1, 0, 0, 0);
        check("guard_done", 32'(bus.irq_done), 32'd0);
        check("guard_req", 32'(bus.int_req), 32'd0);
        step(0, 1, 0, 0, 0);
        check("b2b_req", 32'(bus.int_req), 32'd1);
        check("b2b_vec", 32'(bus.int_vector), 32'd0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Latched vector 3 survives y change and IRQ drop; stray eoi; ack+eoi together
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 0, 0);
        check("hold_req", 32'(bus.int_req), 32'd1);
        check("hold_vec", 32'(bus.int_vector), 32'd3);
        step(0, 0, 0, 0, 1);
        check("stray_eoi_req", 32'(bus.int_req), 32'd1);
        check("stray_eoi_done", 32'(bus.irq_done), 32'd0);
        step(0, 0, 0, 1, 1);
        check("ackeoi_svc", 32'(bus.in_service), 32'h8);
        check("ackeoi_done", 32'(bus.irq_done), 32'd0);
        step(0, 0, 0, 1, 0);
        check("svc_ack_svc", 32'(bus.in_service), 32'h8);
        check("svc_ack_clear", 32'(bus.irq_clear), 32'd0);

        // Reset mid-service with an eoi present
        step(1, 0, 0, 0, 1);
        check("midrst_svc", 32'(bus.in_service), 32'd0);
        check("midrst_done", 32'(bus.irq_done), 32'd0);
        check("midrst_vec", 32'(bus.int_vector), 32'd0);

        // Stray ack in IDLE
        step(0, 0, 0, 1, 0);
        check("idle_ack_req", 32'(bus.int_req), 32'd0);
        check("idle_ack_clear", 32'(bus.irq_clear), 32'd0);

`ifdef IRQ_ACK_TIMEOUT_EN
        // Unacknowledged request is abandoned after ACK_TIMEOUT REQ cycles
        step(0, 1, 1, 0, 0);
        for (int i = 1; i < int'(ACK_TIMEOUT); i++) begin
            step(0, 1, 1, 0, 0);
            check("tmo_wait_req", 32'(bus.int_req), 32'd1);
        end
        step(0, 1, 1, 0, 0);
        check("tmo_req", 32'(bus.int_req), 32'd0);
        check("tmo_err", 32'(bus.timeout_err), 32'd1);
        check("tmo_clear", 32'(bus.irq_clear), 32'd0);
        step(0, 1, 1, 0, 0);
        check("tmo_guard_err", 32'(bus.timeout_err), 32'd0);
        step(0, 1, 1, 0, 0);
        check("tmo_reissue", 32'(bus.int_req), 32'd1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(1) == 1),
                 int'($urandom_range(3)), ($urandom_range(5) == 0),
                 ($urandom_range(3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
